aes_byte_feeder: RTL
====================

# aes_byte_feeder

Transmit-side counterpart of the AES board-level byte loader. It takes one 128-bit block through a valid/ready handshake and replays it as the 16-step switch/push-button sequence the loader expects: the byte is driven on the switch lines, then a clean push strobe is issued, then the lines are held through a gap. It sits between a host-side or test-side block source and the AES top-level switch/button inputs. This lets benches and on-chip sources load plaintext without manual button presses.

## Interface
- BYTES, 16: bytes per block; block width is 8*BYTES.
- PULSE_CYCLES, 1: push strobe high time in clocks, must be at least 1.
- GAP_CYCLES, 1: push low time after each strobe, byte still held, must be at least 1.

- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- blk_valid  in  1  source has a block on blk_data.
- blk_ready  out  1  feeder can accept a block; transfer occurs when blk_valid and blk_ready are both high on a clk edge.
- blk_data  in  8*BYTES  block to send; bits [8*BYTES-1 -: 8] are sent first (MSB-first byte order).
- abort  in  1  synchronous cancel of the current block.
- sw_byte  out  8  switch-line byte, sw_byte[7] maps to sw0.
- push_btn  out  1  push strobe toward the loader.
- busy  out  1  high from acceptance until the return to IDLE.
- done  out  1  one-cycle pulse when the last byte's gap completes.

## Operation
- Block is captured into an internal shift register on handshake; blk_data is not used after that.
- FSM states: IDLE, SETUP, PULSE, GAP.
- IDLE: blk_ready=1, push_btn=0. On handshake go to SETUP with byte index 0.
- SETUP (1 cycle): sw_byte = current byte, push_btn=0. Then go to PULSE.
- PULSE (PULSE_CYCLES cycles): push_btn=1, sw_byte held. Then go to GAP.
- GAP (GAP_CYCLES cycles): push_btn=0, sw_byte held. Then:
  - if index = BYTES-1, go to IDLE with done=1;
  - otherwise shift the register left 8 bits, increment index, and go to SETUP.
- sw_byte never changes while push_btn=1 or in the cycle before or after a strobe.
- Exactly BYTES rising edges of push_btn are produced per block.
- abort in any non-IDLE state:
  - go to IDLE on the next edge; push_btn=0 and sw_byte=0 from that edge;
  - no done pulse; the index is cleared.
- abort in IDLE: no effect. It does not block a simultaneous handshake.
- All outputs are registered.
- Index counter width is clog2(BYTES). Timer width is clog2(max(PULSE_CYCLES,GAP_CYCLES)+1). The timer reloads on every state entry.

## Timing
- Reset values: sw_byte=0, push_btn=0, blk_ready=0, busy=0, done=0, state=IDLE. blk_ready rises on the first edge after rst_n deasserts.
- Let E0 be the handshake edge. For byte i, with per-byte period T = 1+PULSE_CYCLES+GAP_CYCLES:
  - SETUP is entered at edge E0+T*i;
  - push_btn rises at edge E0+T*i+1.
- done=1, blk_ready=1, busy=0 all take effect at edge E0+BYTES*T. The default latency is 48 cycles.
- A new handshake in the done cycle is legal: the next SETUP starts one edge later, with no dead cycle beyond IDLE.
- Asynchronous reset mid-block forces all outputs to their reset values immediately. The partial block is discarded.

## Structure
- Shared package aes_io_pkg holds:
  - the feeder_state_t enum (IDLE, SETUP, PULSE, GAP);
  - the AES_BLOCK_BYTES=16 constant;
  - the default PULSE/GAP constants, which are also used by the loader-side debounce.
- One natural sub-module is aes_io_timer: a loadable down-counter with a zero flag, parameterised width. It is reusable by the loader.

## Test plan
- Reset then idle: hold rst_n=0 for 3 cycles, then release → all outputs 0 during reset; blk_ready=1 one edge after release; push_btn stays 0 for 20 idle cycles.
- Nominal block 0x000102…0F (defaults) → 16 push_btn pulses, each 1 cycle wide, spaced 3 cycles apart; sw_byte = 00,01,…,0F on the respective strobes; done pulses at E0+48.
- Parameter variant PULSE_CYCLES=4, GAP_CYCLES=2, block all-FF → each strobe is 4 cycles high; sw_byte=FF stable across each strobe ±1 cycle; done at E0+112.
- Back-to-back blocks A=0x11…11 and B=0x22…22, with blk_valid held high → B is accepted in A's done cycle; 32 strobes total; first B strobe at A_done+2.
- abort asserted during the 6th PULSE → push_btn=0 and sw_byte=0 on the next edge; no done; the next block restarts at byte 0.
- rst_n pulled low during the 10th GAP → outputs 0 immediately; after release, a fresh block is sent in full with 16 strobes.

Source files
------------

// File: rtl/aes_io_pkg.sv
// Shared types and defaults for the AES board-level byte I/O blocks
// (feeder on the transmit side, loader/debounce on the receive side).
package aes_io_pkg;

  localparam int AES_BLOCK_BYTES  = 16;
  // Strobe timing defaults; the loader-side debounce is sized from these too.
  localparam int AES_PULSE_CYCLES = 1;
  localparam int AES_GAP_CYCLES   = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    GAP   = 2'd3
  } feeder_state_t;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/aes_io_timer.sv
// Loadable down-counter with a zero flag. Counts down to 0 and parks there;
// a load takes priority over counting.
module aes_io_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: reload, else decrement until zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)             cnt_d = load_val_i;
    else if (cnt_q != '0)   cnt_d = cnt_q - W'(1);
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/aes_byte_feeder.sv
// Replays one 128-bit block as a byte-per-strobe switch/push-button sequence:
// SETUP drives the byte, PULSE raises push_btn, GAP holds the byte with the
// button released. All outputs are registered from the next-state decode.
module aes_byte_feeder
  import aes_io_pkg::*;
#(
  parameter int BYTES        = AES_BLOCK_BYTES,
  parameter int PULSE_CYCLES = AES_PULSE_CYCLES,
  parameter int GAP_CYCLES   = AES_GAP_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               blk_valid,
  output logic               blk_ready,
  input  logic [8*BYTES-1:0] blk_data,
  input  logic               abort,
  output logic [7:0]         sw_byte,
  output logic               push_btn,
  output logic               busy,
  output logic               done
);

  localparam int BW = 8 * BYTES;
  localparam int IW = imax(1, $clog2(BYTES));
  localparam int TW = imax(1, $clog2(imax(PULSE_CYCLES, GAP_CYCLES) + 1));

  feeder_state_t state_q, state_d;
  logic [BW-1:0] shift_q, shift_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    sw_q, sw_d;
  logic          push_q, push_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_zero;

  // ready_q is only ever high in IDLE, so it doubles as the accept qualifier
  logic hs;
  assign hs = blk_valid & ready_q;

  // Next-state, shift register, index and byte-line decode
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    sw_d    = sw_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          state_d = SETUP;
          shift_d = blk_data;
          idx_d   = '0;
          sw_d    = blk_data[BW-1 -: 8];
        end
      end
      SETUP: state_d = PULSE;
      PULSE: if (tmr_zero) state_d = GAP;
      GAP: begin
        if (tmr_zero) begin
          if (idx_q == IW'(BYTES - 1)) begin
            state_d = IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            state_d = SETUP;
            shift_d = shift_q << 8;
            idx_d   = idx_q + IW'(1);
            sw_d    = shift_d[BW-1 -: 8];
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Cancel wins over everything outside IDLE; lines are released at once
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      idx_d   = '0;
      sw_d    = 8'h00;
      done_d  = 1'b0;
    end
  end

  // Registered-output decode from the next state
  always_comb begin
    push_d  = (state_d == PULSE);
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  // Timer reloads on every state entry with that state's dwell minus one
  always_comb begin
    tmr_load = (state_d != state_q);
    tmr_val  = '0;
    if (state_d == PULSE)    tmr_val = TW'(PULSE_CYCLES - 1);
    else if (state_d == GAP) tmr_val = TW'(GAP_CYCLES - 1);
  end

  aes_io_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      sw_q    <= 8'h00;
      push_q  <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      sw_q    <= sw_d;
      push_q  <= push_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sw_byte   = sw_q;
  assign push_btn  = push_q;
  assign blk_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
